// File: rtl/ysyx_22050710_mem_stage.sv
// rtl/ysyx_22050710_mem_stage.sv - memory-access pipeline stage with buffered load response
module ysyx_22050710_mem_stage #(
   parameter int GPR_WD          = 64,
   parameter int GPR_ADDR_WD     = 5,
   parameter int CSR_WD          = 64,
   parameter int CSR_ADDR_WD     = 12,
   parameter int SRAM_DATA_WD    = 64,
   parameter int ES_TO_MS_BUS_WD = 216,
   parameter int MS_TO_WS_BUS_WD = 147,
   parameter int BYPASS_BUS_WD   = 145
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_ws_allowin,
   output logic                       o_ms_allowin,
   input  logic                       i_es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
   input  logic                       i_data_sram_rvalid,
   input  logic [SRAM_DATA_WD-1:0]    i_data_sram_rdata,
   output logic                       o_ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
   output logic [BYPASS_BUS_WD-1:0]   o_ms_to_ds_bypass_bus,
   output logic                       o_ms_to_ds_load_stall
);

   // WAIT: load outstanding; HOLD: response captured but writeback not yet ready
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic                       ms_valid;
   logic                       ms_ready_go;
   logic [ES_TO_MS_BUS_WD-1:0] bus_r;
   logic [SRAM_DATA_WD-1:0]    data_buf;
   logic                       load_in;

   logic [GPR_ADDR_WD-1:0]     rd;
   logic [CSR_ADDR_WD-1:0]     csr;
   logic                       gpr_wen;
   logic                       csr_wen;
   logic                       mem_ren;
   logic [2:0]                 mem_op;
   logic                       csr_inst_sel;
   logic [GPR_WD-1:0]          csrrdata;
   logic [GPR_WD-1:0]          alu_result;
   logic [CSR_WD-1:0]          csr_result;

   logic [SRAM_DATA_WD-1:0]    load_raw;
   logic [SRAM_DATA_WD-1:0]    shifted;
   logic [GPR_WD-1:0]          load_data;
   logic [GPR_WD-1:0]          gpr_wdata;

   assign rd           = bus_r[215:211];
   assign csr          = bus_r[210:199];
   assign gpr_wen      = bus_r[198];
   assign csr_wen      = bus_r[197];
   assign mem_ren      = bus_r[196];
   assign mem_op       = bus_r[195:193];
   assign csr_inst_sel = bus_r[192];
   assign csrrdata     = bus_r[191:128];
   assign alu_result   = bus_r[127:64];
   assign csr_result   = bus_r[63:0];

   assign ms_ready_go = !mem_ren || (state == S_HOLD) ||
                        ((state == S_WAIT) && i_data_sram_rvalid);
   assign o_ms_allowin          = !ms_valid || (ms_ready_go && i_ws_allowin);
   assign o_ms_to_ws_valid      = ms_valid && ms_ready_go;
   assign o_ms_to_ds_load_stall = ms_valid && mem_ren && !ms_ready_go;
   assign load_in = o_ms_allowin && i_es_to_ms_valid && i_es_to_ms_bus[196];

   // Pipeline valid bit and instruction bus register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ms_valid <= 1'b0;
         bus_r    <= '0;
      end else if (o_ms_allowin) begin
         ms_valid <= i_es_to_ms_valid;
         if (i_es_to_ms_valid) begin
            bus_r <= i_es_to_ms_bus;
         end
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; rvalid outside WAIT is a stray pulse and is ignored
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (load_in) state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_data_sram_rvalid) begin
               if (i_ws_allowin) state_nxt = load_in ? S_WAIT : S_IDLE;
               else              state_nxt = S_HOLD;
            end
         end
         S_HOLD: if (i_ws_allowin) state_nxt = load_in ? S_WAIT : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Keep the response while writeback back-pressures; rdata may change afterwards
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         data_buf <= '0;
      end else if ((state == S_WAIT) && i_data_sram_rvalid && !i_ws_allowin) begin
         data_buf <= i_data_sram_rdata;
      end
   end

   // Align the addressed bytes to bit 0, then size and extend per load type
   always_comb begin
      load_raw  = (state == S_HOLD) ? data_buf : i_data_sram_rdata;
      shifted   = load_raw >> {alu_result[2:0], 3'b000};
      load_data = '0;
      case (mem_op)
         3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
         3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
         3'b011:  load_data = shifted;
         3'b100:  load_data = {56'd0, shifted[7:0]};
         3'b101:  load_data = {48'd0, shifted[15:0]};
         3'b110:  load_data = {32'd0, shifted[31:0]};
         default: load_data = '0;
      endcase
   end

   assign gpr_wdata = mem_ren ? load_data : (csr_inst_sel ? csrrdata : alu_result);

   assign o_ms_to_ws_bus = {rd, csr, gpr_wen, csr_wen, gpr_wdata, csr_result};

   assign o_ms_to_ds_bypass_bus = ms_valid ?
      {rd & {GPR_ADDR_WD{gpr_wen}}, gpr_wdata & {GPR_WD{gpr_wen}},
       csr & {CSR_ADDR_WD{csr_wen}}, csr_result & {CSR_WD{csr_wen}}} : '0;

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
// tb/tb_ysyx_22050710_mem_stage.sv - directed self-checking bench for the memory stage
module tb_ysyx_22050710_mem_stage;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ws_allowin;
   logic         ms_allowin;
   logic         es_valid;
   logic [215:0] es_bus;
   logic         rvalid;
   logic [63:0]  rdata;
   logic         ws_valid;
   logic [146:0] ws_bus;
   logic [144:0] bp_bus;
   logic         load_stall;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ysyx_22050710_mem_stage dut (
      .i_clk                 (clk),
      .i_rst                 (rst_n),
      .i_ws_allowin          (ws_allowin),
      .o_ms_allowin          (ms_allowin),
      .i_es_to_ms_valid      (es_valid),
      .i_es_to_ms_bus        (es_bus),
      .i_data_sram_rvalid    (rvalid),
      .i_data_sram_rdata     (rdata),
      .o_ms_to_ws_valid      (ws_valid),
      .o_ms_to_ws_bus        (ws_bus),
      .o_ms_to_ds_bypass_bus (bp_bus),
      .o_ms_to_ds_load_stall (load_stall)
   );

   logic [4:0]  ws_rd;
   logic [11:0] ws_csr;
   logic [63:0] ws_gpr;
   logic [63:0] ws_csrw;
   logic [4:0]  bp_rd;
   logic [63:0] bp_gpr;
   logic [11:0] bp_csr;
   logic [63:0] bp_csrw;
   assign ws_rd   = ws_bus[146:142];
   assign ws_csr  = ws_bus[141:130];
   assign ws_gpr  = ws_bus[127:64];
   assign ws_csrw = ws_bus[63:0];
   assign bp_rd   = bp_bus[144:140];
   assign bp_gpr  = bp_bus[139:76];
   assign bp_csr  = bp_bus[75:64];
   assign bp_csrw = bp_bus[63:0];

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  off;
      logic [63:0] rd_data;
      logic [63:0] exp;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   localparam logic [63:0] DA = 64'hF1E2_D3C4_B5A6_9788;
   localparam logic [63:0] DB = 64'h8000_0001_0000_0000;
   localparam logic [63:0] R1 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] R2 = 64'h5555_6666_7777_8888;
   localparam logic [63:0] R3 = 64'h9999_AAAA_BBBB_CCCC;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [215:0] mk(input logic [4:0] rd, input logic [11:0] csr,
                                       input logic gw, input logic cw, input logic mr,
                                       input logic [2:0] op, input logic sel,
                                       input logic [63:0] crd, input logic [63:0] alu,
                                       input logic [63:0] cres);
      return {rd, csr, gw, cw, mr, op, sel, crd, alu, cres};
   endfunction

   function automatic logic [215:0] ld(input logic [2:0] op, input logic [2:0] off);
      logic [63:0] a;
      a = 64'h8000_0000;
      a[2:0] = off;
      return mk(5'd7, 12'h0, 1'b1, 1'b0, 1'b1, op, 1'b0, 64'h0, a, 64'h0);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      #4;
   endtask

   initial begin
      vecs[0]  = '{3'b000, 3'd0, DA, 64'hFFFF_FFFF_FFFF_FF88};
      vecs[1]  = '{3'b000, 3'd3, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80};
      vecs[2]  = '{3'b000, 3'd2, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[3]  = '{3'b001, 3'd2, DA, 64'hFFFF_FFFF_FFFF_B5A6};
      vecs[4]  = '{3'b001, 3'd4, DB, 64'h0000_0000_0000_0001};
      vecs[5]  = '{3'b010, 3'd4, DA, 64'hFFFF_FFFF_F1E2_D3C4};
      vecs[6]  = '{3'b010, 3'd4, DB, 64'hFFFF_FFFF_8000_0001};
      vecs[7]  = '{3'b011, 3'd0, DA, DA};
      vecs[8]  = '{3'b100, 3'd7, DA, 64'h0000_0000_0000_00F1};
      vecs[9]  = '{3'b101, 3'd6, DB, 64'h0000_0000_0000_8000};
      vecs[10] = '{3'b110, 3'd4, DB, 64'h0000_0000_8000_0001};
      vecs[11] = '{3'b111, 3'd0, DA, 64'h0};
      vecs[12] = '{3'b010, 3'd6, DA, 64'h0000_0000_0000_F1E2};
      vecs[13] = '{3'b001, 3'd7, DA, 64'h0000_0000_0000_00F1};
      vecs[14] = '{3'b011, 3'd4, DA, 64'h0000_0000_F1E2_D3C4};

      rst_n = 1'b0; es_valid = 1'b0; es_bus = '0; rvalid = 1'b0; rdata = '0; ws_allowin = 1'b1;
      repeat (2) cyc();
      smp();
      check("rst_allowin", ms_allowin, 1);
      check("rst_valid", ws_valid, 0);
      check("rst_ws_bus", ws_bus, 0);
      check("rst_bypass", bp_bus, 0);
      check("rst_stall", load_stall, 0);

      cyc();
      rst_n = 1'b1;
      es_valid = 1'b1;
      es_bus = mk(5'd5, 12'h7FF, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'hDEAD, 64'h1234, 64'h99);
      cyc();
      es_valid = 1'b0;
      smp();
      check("alu_valid", ws_valid, 1);
      check("alu_gpr", ws_gpr, 64'h1234);
      check("alu_ws_rd", ws_rd, 5);
      check("alu_bp_rd", bp_rd, 5);
      check("alu_bp_gpr", bp_gpr, 64'h1234);
      check("alu_bp_csr_mask", bp_csr, 0);
      check("alu_stall", load_stall, 0);

      cyc();
      es_valid = 1'b1;
      es_bus = mk(5'd3, 12'h300, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 64'hAAAA, 64'h1111, 64'h5555);
      cyc();
      es_valid = 1'b0;
      smp();
      check("csr_gpr", ws_gpr, 64'hAAAA);
      check("csr_wdata", ws_csrw, 64'h5555);
      check("csr_ws_csr", ws_csr, 12'h300);
      check("csr_bp_csr", bp_csr, 12'h300);
      check("csr_bp_csrw", bp_csrw, 64'h5555);

      cyc();
      es_valid = 1'b1;
      es_bus = mk(5'd9, 12'h123, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 64'h77, 64'h88);
      cyc();
      es_valid = 1'b0;
      smp();
      check("nowen_valid", ws_valid, 1);
      check("nowen_bypass", bp_bus, 0);
      cyc();

      for (int i = 0; i < NV; i++) begin
         es_valid = 1'b1;
         es_bus = ld(vecs[i].op, vecs[i].off);
         rvalid = 1'b0;
         ws_allowin = 1'b1;
         cyc();
         es_valid = 1'b0;
         smp();
         check($sformatf("vec%0d_stall", i), load_stall, 1);
         cyc();
         rvalid = 1'b1;
         rdata = vecs[i].rd_data;
         smp();
         check($sformatf("vec%0d_valid", i), ws_valid, 1);
         check($sformatf("vec%0d_data", i), ws_gpr, vecs[i].exp);
         cyc();
         rvalid = 1'b0;
      end

      es_valid = 1'b1;
      es_bus = ld(3'b000, 3'd3);
      rdata = 64'h0000_0000_80FF_0000;
      for (int k = 0; k < 3; k++) begin
         cyc();
         es_valid = 1'b0;
         smp();
         check($sformatf("lb_stall%0d", k), load_stall, 1);
         check($sformatf("lb_novalid%0d", k), ws_valid, 0);
      end
      cyc();
      rvalid = 1'b1;
      smp();
      check("lb_stall_end", load_stall, 0);
      check("lb_valid", ws_valid, 1);
      check("lb_data", ws_gpr, 64'hFFFF_FFFF_FFFF_FF80);
      cyc();
      rvalid = 1'b0;

      es_valid = 1'b1;
      es_bus = ld(3'b011, 3'd0);
      ws_allowin = 1'b0;
      cyc();
      es_valid = 1'b0;
      smp();
      check("hold_wait_stall", load_stall, 1);
      cyc();
      rvalid = 1'b1;
      rdata = R1;
      smp();
      check("hold_rv_valid", ws_valid, 1);
      check("hold_rv_allowin", ms_allowin, 0);
      check("hold_rv_data", ws_gpr, R1);
      cyc();
      rdata = R2;
      smp();
      check("hold_stray_data", ws_gpr, R1);
      check("hold_stray_allowin", ms_allowin, 0);
      check("hold_stray_valid", ws_valid, 1);
      cyc();
      rvalid = 1'b0;
      rdata = R3;
      smp();
      check("hold_data2", ws_gpr, R1);
      cyc();
      ws_allowin = 1'b1;
      smp();
      check("hold_rel_allowin", ms_allowin, 1);
      check("hold_rel_valid", ws_valid, 1);
      check("hold_rel_data", ws_gpr, R1);
      cyc();
      smp();
      check("hold_after_valid", ws_valid, 0);
      check("hold_after_stall", load_stall, 0);

      cyc();
      es_valid = 1'b1;
      es_bus = ld(3'b011, 3'd0);
      ws_allowin = 1'b0;
      cyc();
      es_valid = 1'b0;
      cyc();
      rvalid = 1'b1;
      rdata = R1;
      cyc();
      rvalid = 1'b0;
      rdata = R2;
      ws_allowin = 1'b1;
      es_valid = 1'b1;
      es_bus = ld(3'b110, 3'd4);
      smp();
      check("b2b_rel_allowin", ms_allowin, 1);
      check("b2b_rel_data", ws_gpr, R1);
      cyc();
      es_valid = 1'b0;
      smp();
      check("b2b_no_dup", ws_valid, 0);
      check("b2b_wait_stall", load_stall, 1);
      cyc();
      rvalid = 1'b1;
      rdata = DB;
      es_valid = 1'b1;
      es_bus = ld(3'b101, 3'd6);
      smp();
      check("b2b_lwu_valid", ws_valid, 1);
      check("b2b_lwu_data", ws_gpr, 64'h0000_0000_8000_0001);
      cyc();
      es_valid = 1'b0;
      rvalid = 1'b0;
      smp();
      check("b2b2_no_dup", ws_valid, 0);
      check("b2b2_stall", load_stall, 1);
      cyc();
      rvalid = 1'b1;
      smp();
      check("b2b_lhu_data", ws_gpr, 64'h0000_0000_0000_8000);
      cyc();
      rvalid = 1'b0;
      smp();
      check("b2b_end_valid", ws_valid, 0);
      check("b2b_end_stall", load_stall, 0);

      cyc();
      es_valid = 1'b1;
      es_bus = ld(3'b011, 3'd0);
      cyc();
      es_valid = 1'b0;
      smp();
      check("rstw_stall", load_stall, 1);
      cyc();
      rst_n = 1'b0;
      smp();
      check("rstw_allowin", ms_allowin, 1);
      check("rstw_valid", ws_valid, 0);
      check("rstw_ws_bus", ws_bus, 0);
      check("rstw_bypass", bp_bus, 0);
      check("rstw_stall0", load_stall, 0);
      cyc();
      rst_n = 1'b1;
      rvalid = 1'b1;
      rdata = R1;
      smp();
      check("stray_valid", ws_valid, 0);
      check("stray_stall", load_stall, 0);
      check("stray_allowin", ms_allowin, 1);
      cyc();
      rvalid = 1'b0;
      es_valid = 1'b1;
      es_bus = ld(3'b011, 3'd0);
      cyc();
      es_valid = 1'b0;
      smp();
      check("post_rst_stall", load_stall, 1);
      check("post_rst_novalid", ws_valid, 0);
      cyc();
      rvalid = 1'b1;
      rdata = R2;
      smp();
      check("post_rst_data", ws_gpr, R2);
      cyc();
      rvalid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
